// File: rtl/ibuf_skew_feeder.sv
// Input buffer and systolic skew stage for the NxN MAC array: captures N rows, then streams lane r delayed by r cycles.
// Optional sticky protocol-error flag ERR is built only when IBUF_SKEW_ERR_EN is defined; otherwise ERR is tied low.
module ibuf_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOAD_EN,
  input  logic [N*DATA_W-1:0] LOAD_DATA,
  input  logic                START_CALC,
  output logic [N*DATA_W-1:0] A_OUT,
  output logic [N-1:0]        A_VALID,
  output logic                FULL,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int CNT_W  = $clog2(N + 1);
  localparam int STEP_W = $clog2(2 * N - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N - 2);
  localparam logic [CNT_W-1:0]  LAST_ROW  = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOADED = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [STEP_W-1:0]   t;
  logic [N*DATA_W-1:0] row_mem [N];
  logic [N*DATA_W-1:0] lane_nxt;
  logic [N-1:0]        valid_nxt;
  logic [N*DATA_W-1:0] a_out_q;
  logic [N-1:0]        a_valid_q;
  logic                done_q;
  int                  tgt_step;

  // Lane r carries element (step - r) of row r; the step being prepared is the one shown next cycle.
  always_comb begin
    lane_nxt  = '0;
    valid_nxt = '0;
    tgt_step  = (state == S_STREAM) ? int'(t) + 1 : 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (tgt_step == r + c) begin
          lane_nxt[r*DATA_W +: DATA_W] = row_mem[r][c*DATA_W +: DATA_W];
          valid_nxt[r]                 = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && state == S_IDLE && LOAD_EN) begin
      for (int r = 0; r < N; r++) begin
        if (cnt == CNT_W'(r)) row_mem[r] <= LOAD_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      t         <= '0;
      a_out_q   <= '0;
      a_valid_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (LOAD_EN) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ROW) state <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (START_CALC) begin
            state     <= S_STREAM;
            t         <= '0;
            a_out_q   <= lane_nxt;
            a_valid_q <= valid_nxt;
          end
        end
        S_STREAM: begin
          // The final step has been on the outputs for one cycle; retire the stream.
          if (t == LAST_STEP) begin
            state     <= S_IDLE;
            cnt       <= '0;
            t         <= '0;
            a_out_q   <= '0;
            a_valid_q <= '0;
            done_q    <= 1'b1;
          end else begin
            t         <= t + STEP_W'(1);
            a_out_q   <= lane_nxt;
            a_valid_q <= valid_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign A_OUT   = a_out_q;
  assign A_VALID = a_valid_q;
  assign DONE    = done_q;
  assign FULL    = (state == S_LOADED);
  assign BUSY    = (state == S_STREAM);

`ifdef IBUF_SKEW_ERR_EN
  logic err_event;
  logic err_q;

  always_comb begin
    err_event = 1'b0;
    case (state)
      S_IDLE:   err_event = START_CALC;
      S_LOADED: err_event = LOAD_EN;
      S_STREAM: err_event = LOAD_EN | START_CALC;
      default:  err_event = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_q | err_event;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ibuf_skew_feeder.sv
// Scoreboard bench for ibuf_skew_feeder: a behavioural model predicts stream beats and DONE cycles,
// a negedge monitor pops and compares them along with FULL/BUSY/ERR.
module tb_ibuf_skew_feeder;
  localparam int N      = 4;
  localparam int DATA_W = 8;

  logic                CLK = 1'b0;
  logic                RST;
  logic                LOAD_EN;
  logic [N*DATA_W-1:0] LOAD_DATA;
  logic                START_CALC;
  logic [N*DATA_W-1:0] A_OUT;
  logic [N-1:0]        A_VALID;
  logic                FULL;
  logic                BUSY;
  logic                DONE;
  logic                ERR;

  ibuf_skew_feeder #(.DATA_W(DATA_W), .N(N)) dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_DATA(LOAD_DATA),
    .START_CALC(START_CALC), .A_OUT(A_OUT), .A_VALID(A_VALID),
    .FULL(FULL), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]        valid;
    logic [N*DATA_W-1:0] data;
  } beat_t;

  typedef enum {M_IDLE, M_LOADED, M_STREAM} mstate_t;

  beat_t   expQ[$];
  int      doneQ[$];
  int      checks = 0;
  int      passes = 0;
  bit      monitorOn = 0;
  mstate_t mState = M_IDLE;
  int      mCnt = 0;
  int      mLeft = 0;
  bit      mErr = 0;
  logic [DATA_W-1:0] mRow [N][N];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour: what one clock edge does given the inputs held during cycle c.
  function automatic void modelUpdate(input bit rst, input bit load, input logic [N*DATA_W-1:0] data,
                                      input bit start, input int c);
    beat_t b;
    if (rst) begin
      mState = M_IDLE; mCnt = 0; mErr = 0;
      expQ.delete(); doneQ.delete();
      return;
    end
    case (mState)
      M_IDLE: begin
        if (start) mErr = 1;
        if (load) begin
          for (int e = 0; e < N; e++) mRow[mCnt][e] = data[e*DATA_W +: DATA_W];
          mCnt++;
          if (mCnt == N) mState = M_LOADED;
        end
      end
      M_LOADED: begin
        if (load) mErr = 1;
        if (start) begin
          for (int s = 0; s <= 2*N-2; s++) begin
            b.valid = '0; b.data = '0;
            for (int r = 0; r < N; r++) begin
              if (s >= r && s - r < N) begin
                b.valid[r] = 1'b1;
                b.data[r*DATA_W +: DATA_W] = mRow[r][s-r];
              end
            end
            expQ.push_back(b);
          end
          doneQ.push_back(c + 2*N);
          mState = M_STREAM;
          mLeft = 2*N - 1;
        end
      end
      M_STREAM: begin
        if (load || start) mErr = 1;
        mLeft--;
        if (mLeft == 0) begin
          mState = M_IDLE;
          mCnt = 0;
        end
      end
      default: mState = M_IDLE;
    endcase
  endfunction

  task automatic applyStimulus(input bit rst, input bit load, input logic [N*DATA_W-1:0] data, input bit start);
    int c;
    RST = rst; LOAD_EN = load; LOAD_DATA = data; START_CALC = start;
    c = cyc;
    @(posedge CLK);
    modelUpdate(rst, load, data, start, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0);
  endtask

  task automatic loadRows(input int n, input logic [N*DATA_W-1:0] base);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, base + (N*DATA_W)'(32'h10101010 * i), 0);
  endtask

  always @(negedge CLK) begin
    beat_t b;
    int    d;
    if (monitorOn) begin
      checkOutput("FULL", FULL, (mState == M_LOADED));
      checkOutput("BUSY", BUSY, (mState == M_STREAM));
`ifdef IBUF_SKEW_ERR_EN
      checkOutput("ERR", ERR, mErr);
`else
      checkOutput("ERR", ERR, 0);
`endif
      if (A_VALID !== '0) begin
        if (expQ.size() == 0) checkOutput("unexpected A_VALID", A_VALID, 0);
        else begin
          b = expQ.pop_front();
          checkOutput("A_VALID", A_VALID, b.valid);
          checkOutput("A_OUT", A_OUT, b.data);
        end
      end else begin
        checkOutput("idle A_OUT", A_OUT, 0);
      end
      if (DONE) begin
        if (doneQ.size() == 0) checkOutput("unexpected DONE", DONE, 0);
        else begin
          d = doneQ.pop_front();
          checkOutput("DONE cycle", cyc, d);
        end
      end
    end
  end

  initial begin
    logic [N*DATA_W-1:0] rdata;
    bit rl, rs, rr;
    RST = 1; LOAD_EN = 0; LOAD_DATA = '0; START_CALC = 0;
    #1;
    applyStimulus(1, 0, '0, 0);
    applyStimulus(1, 0, '0, 0);
    monitorOn = 1;
    idle(1);

    $display("[TB] basic skew");
    loadRows(4, 32'h03020100);
    applyStimulus(0, 0, '0, 1);
    idle(2*N + 1);

    $display("[TB] early start");
    loadRows(2, 32'h43424140);
    applyStimulus(0, 0, '0, 1);
    idle(2);
    loadRows(2, 32'h63626160);
    applyStimulus(0, 0, '0, 1);
    idle(2*N + 1);

    $display("[TB] overflow");
    loadRows(5, 32'h83828180);
    applyStimulus(0, 0, '0, 1);
    idle(2*N + 1);

    $display("[TB] same-cycle conflict");
    loadRows(4, 32'hA3A2A1A0);
    applyStimulus(0, 1, 32'hDEADBEEF, 1);
    idle(2*N + 1);

    $display("[TB] mid-stream reset");
    applyStimulus(1, 0, '0, 0);
    loadRows(4, 32'h0B0A0908);
    applyStimulus(0, 0, '0, 1);
    idle(2);
    applyStimulus(1, 0, '0, 0);
    idle(2);
    loadRows(4, 32'h2B2A2928);
    applyStimulus(0, 0, '0, 1);
    idle(2*N + 1);

    $display("[TB] back-to-back");
    loadRows(4, 32'h57565554);
    applyStimulus(0, 0, '0, 1);
    idle(2*N - 1);
    loadRows(4, 32'h77767574);
    applyStimulus(0, 0, '0, 1);
    idle(2*N + 1);

    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rl = ($urandom_range(0, 99) < 40);
      rs = ($urandom_range(0, 99) < 12);
      rdata = (N*DATA_W)'($urandom());
      applyStimulus(rr, rl, rdata, rs);
    end
    idle(2*N + 2);

    checkOutput("beats left over", expQ.size(), 0);
    checkOutput("DONEs left over", doneQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ibuf_skew_feeder.md
Name: ibuf_skew_feeder

Overview:
- Input-side buffer and skew stage for the NxN MAC array.
- Captures N operand rows while the control FSM holds LOAD_EN, then on a one-cycle START_CALC pulse streams the rows into the array's row lanes with systolic skew: lane r is delayed r cycles.
- Sits between the control FSM and the MAC array. Reports its own completion through DONE.

Parameters:
- DATA_W, 8, bit width of one operand element.
- N, 4, array dimension: lanes, rows stored and elements per row. Legal range 2..8.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- LOAD_EN  in  1  write one row per cycle from LOAD_DATA.
- LOAD_DATA  in  N*DATA_W  one row; element c at bits [c*DATA_W +: DATA_W].
- START_CALC  in  1  one-cycle pulse that starts streaming.
- A_OUT  out  N*DATA_W  lane r at bits [r*DATA_W +: DATA_W]; registered.
- A_VALID  out  N  per-lane valid; registered.
- FULL  out  1  N rows held, ready to stream.
- BUSY  out  1  streaming in progress.
- DONE  out  1  one-cycle pulse after the last lane element.
- ERR  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (RST high at a clock edge):
  - State IDLE; row count 0; stream counter 0.
  - A_OUT=0, A_VALID=0, FULL=0, BUSY=0, DONE=0, ERR=0.
  - Row storage is not cleared.
  - Reset mid-stream aborts the stream. Outputs are zero from the following cycle. No DONE is issued.
- States: IDLE, LOADED, STREAM.
- IDLE:
  - Each LOAD_EN cycle writes LOAD_DATA into row[cnt] and increments cnt.
  - When cnt reaches N, go to LOADED and assert FULL.
  - A partial load keeps its rows. Gaps between LOAD_EN cycles are allowed.
  - START_CALC in IDLE is ignored and counts as an error event.
- LOADED:
  - FULL=1.
  - LOAD_EN is ignored and counts as an error event (overflow). Stored data is unchanged.
  - START_CALC moves to STREAM with t=0. FULL drops the next cycle.
  - LOAD_EN and START_CALC in the same cycle: START wins, the load is dropped and counts as an error event.
- STREAM (START_CALC sampled high in cycle c):
  - Stream counter t runs 0..2N-2. Register updates are such that outputs for step t are visible in cycle c+1+t.
  - Lane r is valid when r <= t <= r+N-1 and then carries row[r][t-r]. Invalid lanes drive 0.
  - Lane 0 is valid in cycles c+1..c+N. Lane N-1 is valid in cycles c+N..c+2N-1.
  - BUSY=1 in cycles c+1..c+2N-1.
  - LOAD_EN and START_CALC during STREAM are ignored and count as error events.
  - After t=2N-2: DONE=1 for exactly cycle c+2N, A_VALID=0, cnt cleared to 0, state IDLE.
  - A new load may begin in cycle c+2N. LOAD_EN sampled in that cycle is accepted.
- Counter widths: cnt holds 0..N; t holds 0..2N-2. No wrap-around occurs because the FSM bounds both counters.

Optional Feature:
- Macro IBUF_SKEW_ERR_EN.
- Defined:
  - ERR sets on any error event: load while FULL, START while not FULL, load or START during STREAM, load dropped by the START priority rule.
  - ERR stays set until RST.
- Undefined:
  - ERR is constant 0.
  - The same events are still silently ignored.
  - No extra logic is generated.

Test Plan (N=4, DATA_W=8):
- Basic skew:
  - Stimulus: LOAD_EN for 4 cycles with rows 0x03020100, 0x13121110, 0x23222120, 0x33323130; START_CALC in cycle c.
  - Response: lane0 = 00,01,02,03 in c+1..c+4. Lane3 = 30,31,32,33 in c+4..c+7. A_VALID in c+4 = 4'b1111. DONE only in c+8. BUSY in c+1..c+7.
- Early start:
  - Stimulus: load 2 rows, START_CALC.
  - Response: no A_VALID, state IDLE, ERR=1 (macro on) / 0 (off). After 2 further loads FULL=1, and the stream carries the 2 original rows plus the 2 new rows.
- Overflow:
  - Stimulus: 5 consecutive LOAD_EN cycles.
  - Response: FULL=1 after the 4th; the 5th is dropped; the streamed data matches the first 4 rows; ERR=1 with the macro.
- Same-cycle conflict:
  - Stimulus: in LOADED, LOAD_EN and START_CALC high together.
  - Response: the stream starts with the old rows; ERR=1 with the macro.
- Mid-stream reset:
  - Stimulus: RST high at c+3.
  - Response: A_VALID=0, BUSY=0, FULL=0 from c+4; no DONE; a fresh 4-row load and start then streams correctly.
- Back-to-back:
  - Stimulus: LOAD_EN starting in the DONE cycle (c+8), then START_CALC.
  - Response: the second load is accepted from c+8 and the second stream output is correct.
